// File: rtl/mem2axi_if.sv
// AXI4 bus bundle used by mem2axi: AR/R/AW/W/B channels with id, user and
// atomic (atop) fields. Master drives requests and response readies, Slave the rest.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/mem2axi.sv
// mem2axi: SRAM-style request port to AXI4 master, one single-beat transaction
// outstanding at a time; the response comes back as a one-cycle rvalid_o pulse.
// Optional: define MEM2AXI_ID_CHECK_EN to flag R/B responses whose id differs
// from AXI_ID as errors.
module mem2axi #(
  parameter int unsigned             AXI_ID_WIDTH   = 10,
  parameter int unsigned             AXI_ADDR_WIDTH = 64,
  parameter int unsigned             AXI_DATA_WIDTH = 64,
  parameter int unsigned             AXI_USER_WIDTH = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_USER_WIDTH-1:0]   user_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_o,
  output logic [AXI_USER_WIDTH-1:0]   user_o,
  output logic                        err_o,
  AXI_BUS.Master                      master
);
  localparam int unsigned LOG_NR_BYTES = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [AXI_ADDR_WIDTH-1:0] LSB_MASK =
    AXI_ADDR_WIDTH'((64'd1 << LOG_NR_BYTES) - 64'd1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] AR   = 3'd1;
  localparam logic [2:0] R    = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] B    = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        rvalid_q, rvalid_d;
  logic                        err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [AXI_USER_WIDTH-1:0]   ruser_q, ruser_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH/8-1:0] be_q, be_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_USER_WIDTH-1:0]   wuser_q, wuser_d;

  logic aw_hs, w_hs, r_id_bad, b_id_bad;

`ifdef MEM2AXI_ID_CHECK_EN
  assign r_id_bad = (master.r_id != AXI_ID);
  assign b_id_bad = (master.b_id != AXI_ID);
`else
  assign r_id_bad = 1'b0;
  assign b_id_bad = 1'b0;
`endif

  // Grant only when idle; held off during reset so nothing is accepted then.
  assign gnt_o    = (state_q == IDLE) && !rst_i;
  assign rvalid_o = rvalid_q;
  assign data_o   = rdata_q;
  assign user_o   = ruser_q;
  assign err_o    = err_q;

  // Read address channel: valid is a pure function of state, so it and the
  // latched payload stay stable until ar_ready.
  assign master.ar_valid  = (state_q == AR);
  assign master.ar_id     = AXI_ID;
  assign master.ar_addr   = addr_q & ~LSB_MASK;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = 3'(LOG_NR_BYTES);
  assign master.ar_burst  = 2'b01;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = wuser_q;
  assign master.r_ready   = (state_q == R);

  // Write channels: AW and W raise together, each drops after its own handshake.
  assign master.aw_valid  = (state_q == WR) && !aw_done_q;
  assign master.aw_id     = AXI_ID;
  assign master.aw_addr   = addr_q & ~LSB_MASK;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = 3'(LOG_NR_BYTES);
  assign master.aw_burst  = 2'b01;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_atop   = 6'd0;
  assign master.aw_user   = wuser_q;
  assign master.w_valid   = (state_q == WR) && !w_done_q;
  assign master.w_data    = wdata_q;
  assign master.w_strb    = be_q;
  assign master.w_last    = 1'b1;
  assign master.w_user    = wuser_q;
  assign master.b_ready   = (state_q == B);

  assign aw_hs = master.aw_valid && master.aw_ready;
  assign w_hs  = master.w_valid && master.w_ready;

  // Next-state and response capture for the single-outstanding FSM.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    ruser_d   = ruser_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wuser_d   = wuser_q;
    unique case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req_i) begin
          addr_d  = addr_i;
          be_d    = be_i;
          wdata_d = data_i;
          wuser_d = user_i;
          state_d = we_i ? WR : AR;
        end
      end
      AR: if (master.ar_ready) state_d = R;
      R: begin
        if (master.r_valid) begin
          rvalid_d = 1'b1;
          rdata_d  = master.r_data;
          ruser_d  = master.r_user;
          err_d    = (master.r_resp != 2'b00) || r_id_bad;
          state_d  = IDLE;
        end
      end
      WR: begin
        // Flags include this cycle's handshakes so a simultaneous finish moves on at once.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = B;
      end
      B: begin
        if (master.b_valid) begin
          rvalid_d = 1'b1;
          err_d    = (master.b_resp != 2'b00) || b_id_bad;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      ruser_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ruser_q   <= ruser_d;
    end
  end

  // Request payload latched at grant; meaningful only while a transaction is open.
  always_ff @(posedge clk_i) begin
    addr_q  <= addr_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
    wuser_q <= wuser_d;
  end

`ifdef MEM2AXI_ID_CHECK_EN
`ifndef SYNTHESIS
  // Flag foreign response ids in simulation.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (((state_q == R) && master.r_valid && r_id_bad) ||
                   ((state_q == B) && master.b_valid && b_id_bad)))
      $error("mem2axi: response id does not match AXI_ID");
  end
`endif
`endif
endmodule

// File: tb/tb_mem2axi.sv
// Self-checking bench for mem2axi: a scripted AXI slave with per-transaction
// ready/response delays, a vector table, a reset-in-flight sequence and random traffic.
module tb_mem2axi;
  localparam int IW = 10;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int UW = 10;
  localparam logic [IW-1:0] ID = '0;
`ifdef MEM2AXI_ID_CHECK_EN
  localparam bit IDCHK = 1'b1;
`else
  localparam bit IDCHK = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [63:0]   addr;
    logic [7:0]    be;
    logic [63:0]   data;
    logic [UW-1:0] user;
    int            lat_a;
    int            lat_w;
    int            lat_r;
    logic [1:0]    resp;
    logic [63:0]   rdata;
    logic [UW-1:0] ruser;
    logic          id_bad;
    int            exp_rt;
    logic          exp_err;
    logic [63:0]   exp_data;
    logic [UW-1:0] exp_user;
    bit            b2b;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [AW-1:0] addr_i;
  logic [7:0]    be_i;
  logic [UW-1:0] user_i, user_o;
  logic [DW-1:0] data_i, data_o;

  int total = 0;
  int bad   = 0;
  logic [63:0]   m_data;
  logic [UW-1:0] m_user;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
            .AXI_USER_WIDTH(UW)) axi ();

  mem2axi #(.AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
            .AXI_USER_WIDTH(UW), .AXI_ID(ID)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .be_i(be_i), .user_i(user_i), .data_i(data_i),
    .rvalid_o(rvalid_o), .data_o(data_o), .user_o(user_o), .err_o(err_o),
    .master(axi)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic slave_quiet();
    axi.ar_ready = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
    axi.r_valid  = 1'b0; axi.b_valid  = 1'b0;
  endtask

  // Idle cycles: nothing in flight, so no pulse, no valids, grant up.
  task automatic idle(input int n);
    req_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); @(negedge clk);
      chk("idle_rvalid", 64'(rvalid_o), 64'd0);
      chk("idle_valids", 64'({axi.ar_valid, axi.aw_valid, axi.w_valid}), 64'd0);
      chk("idle_gnt", 64'(gnt_o), 64'd1);
    end
  endtask

  // One transaction, entered and left at a negedge; req_i stays high while busy.
  task automatic run_txn(input vec_t v);
    logic [63:0] exp_addr;
    int  a_wait, w_wait, r_wait, cyc;
    bit  a_done, w_done, resp_hs, got;
    exp_addr = v.addr & ~64'h7;
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; be_i = v.be;
    data_i = v.data; user_i = v.user;
    chk("grant_gnt", 64'(gnt_o), 64'd1);
    chk("grant_no_valid", 64'({axi.ar_valid, axi.aw_valid, axi.w_valid}), 64'd0);
    @(posedge clk);
    a_wait = 0; w_wait = 0; r_wait = 0;
    a_done = 1'b0; w_done = 1'b0; resp_hs = 1'b0; got = 1'b0;
    for (cyc = 2; cyc <= 60 && !got; cyc++) begin
      @(negedge clk);
      slave_quiet();
      if (axi.ar_valid && axi.aw_valid) chk("one_addr_outstanding", 64'd1, 64'd0);
      if (resp_hs) begin
        chk("rvalid", 64'(rvalid_o), 64'd1);
        chk("gnt_with_rvalid", 64'(gnt_o), 64'd1);
        chk("err_o", 64'(err_o), 64'(v.exp_err));
        chk("data_o", data_o, v.exp_data);
        chk("user_o", 64'(user_o), 64'(v.exp_user));
        if (v.exp_rt != 0) chk("round_trip", 64'(cyc), 64'(v.exp_rt));
        got = 1'b1;
      end else begin
        chk("rvalid_quiet", 64'(rvalid_o), 64'd0);
        chk("gnt_busy", 64'(gnt_o), 64'd0);
        if (cyc == 2)
          chk("valid_latency", 64'(v.we ? (axi.aw_valid && axi.w_valid) : axi.ar_valid), 64'd1);
        if (!v.we) begin
          if (!a_done) begin
            chk("ar_valid", 64'(axi.ar_valid), 64'd1);
            chk("ar_addr", axi.ar_addr, exp_addr);
            chk("ar_ctrl", {31'd0, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_id, axi.ar_user},
                {31'd0, 8'd0, 3'd3, 2'b01, ID, v.user});
            chk("ar_tieoff", 64'({axi.ar_lock, axi.ar_cache, axi.ar_prot, axi.ar_qos, axi.ar_region}), 64'd0);
            axi.ar_ready = (a_wait == v.lat_a);
            if (axi.ar_ready) a_done = 1'b1; else a_wait++;
          end else begin
            chk("ar_valid_dropped", 64'(axi.ar_valid), 64'd0);
            chk("r_ready", 64'(axi.r_ready), 64'd1);
            if (r_wait == v.lat_r) begin
              axi.r_valid = 1'b1; axi.r_data = v.rdata; axi.r_user = v.ruser;
              axi.r_resp = v.resp; axi.r_last = 1'b1; axi.r_id = v.id_bad ? ID + 1'b1 : ID;
              resp_hs = 1'b1;
            end else r_wait++;
          end
        end else begin
          if (!(a_done && w_done)) begin
            chk("aw_valid", 64'(axi.aw_valid), 64'(!a_done));
            chk("w_valid", 64'(axi.w_valid), 64'(!w_done));
            chk("b_ready_early", 64'(axi.b_ready), 64'd0);
            if (!a_done) begin
              chk("aw_addr", axi.aw_addr, exp_addr);
              chk("aw_ctrl", {31'd0, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_id, axi.aw_user},
                  {31'd0, 8'd0, 3'd3, 2'b01, ID, v.user});
              chk("aw_tieoff", 64'({axi.aw_lock, axi.aw_cache, axi.aw_prot, axi.aw_qos,
                                    axi.aw_region, axi.aw_atop}), 64'd0);
              axi.aw_ready = (a_wait == v.lat_a);
              if (!axi.aw_ready) a_wait++;
            end
            if (!w_done) begin
              chk("w_data", axi.w_data, v.data);
              chk("w_misc", 64'({axi.w_strb, axi.w_last, axi.w_user}), 64'({v.be, 1'b1, v.user}));
              axi.w_ready = (w_wait == v.lat_w);
              if (!axi.w_ready) w_wait++;
            end
            if (axi.aw_ready) a_done = 1'b1;
            if (axi.w_ready)  w_done = 1'b1;
          end else begin
            chk("aw_w_dropped", 64'({axi.aw_valid, axi.w_valid}), 64'd0);
            chk("b_ready", 64'(axi.b_ready), 64'd1);
            if (r_wait == v.lat_r) begin
              axi.b_valid = 1'b1; axi.b_resp = v.resp; axi.b_user = '0;
              axi.b_id = v.id_bad ? ID + 1'b1 : ID;
              resp_hs = 1'b1;
            end else r_wait++;
          end
        end
      end
    end
    if (!got) chk("txn_timeout", 64'd0, 64'd1);
    if (!v.we) begin m_data = v.rdata; m_user = v.ruser; end
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; user_i = '0; data_i = '0;
    slave_quiet();
    axi.r_data = '0; axi.r_user = '0; axi.r_resp = '0; axi.r_last = 1'b0; axi.r_id = '0;
    axi.b_resp = '0; axi.b_user = '0; axi.b_id = '0;
    m_data = '0; m_user = '0;

    tbl[0] = '{we:0, addr:64'h1000, be:8'hFF, data:64'h0, user:10'h000, lat_a:0, lat_w:0, lat_r:0,
               resp:2'b00, rdata:64'hDEADBEEF_CAFEF00D, ruser:10'h015, id_bad:0, exp_rt:4,
               exp_err:0, exp_data:64'hDEADBEEF_CAFEF00D, exp_user:10'h015, b2b:0};
    tbl[1] = '{we:1, addr:64'h2008, be:8'h0F, data:64'h11223344_55667788, user:10'h02A, lat_a:3, lat_w:0,
               lat_r:0, resp:2'b00, rdata:64'h0, ruser:10'h000, id_bad:0, exp_rt:7,
               exp_err:0, exp_data:64'hDEADBEEF_CAFEF00D, exp_user:10'h015, b2b:0};
    tbl[2] = '{we:1, addr:64'h3010, be:8'hFF, data:64'hAAAA5555_AAAA5555, user:10'h001, lat_a:0, lat_w:0,
               lat_r:0, resp:2'b10, rdata:64'h0, ruser:10'h000, id_bad:0, exp_rt:4,
               exp_err:1, exp_data:64'hDEADBEEF_CAFEF00D, exp_user:10'h015, b2b:0};
    tbl[3] = '{we:0, addr:64'h3018, be:8'hFF, data:64'h0, user:10'h007, lat_a:0, lat_w:0, lat_r:0,
               resp:2'b11, rdata:64'h01234567_89ABCDEF, ruser:10'h3FF, id_bad:0, exp_rt:4,
               exp_err:1, exp_data:64'h01234567_89ABCDEF, exp_user:10'h3FF, b2b:1};
    tbl[4] = '{we:0, addr:64'h4007, be:8'hFF, data:64'h0, user:10'h055, lat_a:2, lat_w:0, lat_r:1,
               resp:2'b00, rdata:64'h55AA55AA_0F0F0F0F, ruser:10'h002, id_bad:1, exp_rt:7,
               exp_err:IDCHK, exp_data:64'h55AA55AA_0F0F0F0F, exp_user:10'h002, b2b:0};
    tbl[5] = '{we:1, addr:64'h5000, be:8'hA5, data:64'hCAFE0000_BEEF0000, user:10'h111, lat_a:0, lat_w:2,
               lat_r:2, resp:2'b00, rdata:64'h0, ruser:10'h000, id_bad:1, exp_rt:8,
               exp_err:IDCHK, exp_data:64'h55AA55AA_0F0F0F0F, exp_user:10'h002, b2b:1};
    tbl[6] = '{we:0, addr:64'h6FF8, be:8'hFF, data:64'h0, user:10'h0F0, lat_a:1, lat_w:0, lat_r:0,
               resp:2'b00, rdata:64'hFFFF0000_12345678, ruser:10'h100, id_bad:0, exp_rt:5,
               exp_err:0, exp_data:64'hFFFF0000_12345678, exp_user:10'h100, b2b:1};
    tbl[7] = '{we:1, addr:64'h7770, be:8'hFF, data:64'h0BAD_F00D_0BAD_F00D, user:10'h00F, lat_a:1, lat_w:1,
               lat_r:0, resp:2'b01, rdata:64'h0, ruser:10'h000, id_bad:0, exp_rt:5,
               exp_err:1, exp_data:64'hFFFF0000_12345678, exp_user:10'h100, b2b:1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_axi_quiet", 64'({axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt_o), 64'd1);
    chk("rst_outputs", 64'({rvalid_o, err_o, user_o}), 64'd0);
    chk("rst_data", data_o, 64'd0);
    idle(1);

    for (int i = 0; i < 8; i++) begin
      if (!tbl[i].b2b) idle(1);
      run_txn(tbl[i]);
    end
    idle(2);

    // Reset while in R waiting for r_valid.
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h8000; user_i = 10'h0AB;
    @(posedge clk); @(negedge clk);
    req_i = 1'b0;
    chk("rstseq_ar_valid", 64'(axi.ar_valid), 64'd1);
    axi.ar_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    axi.ar_ready = 1'b0;
    chk("rstseq_in_r", 64'(axi.r_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rstseq_valids", 64'({axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready}), 64'd0);
    chk("rstseq_no_rvalid", 64'(rvalid_o), 64'd0);
    chk("rstseq_data", data_o, 64'd0);
    rst = 1'b0;
    #1;
    chk("rstseq_gnt", 64'(gnt_o), 64'd1);
    m_data = '0; m_user = '0;
    idle(3);

    // Random traffic against the spec-level model.
    for (int n = 0; n < 40; n++) begin
      rv.we     = $urandom_range(0, 1) == 1;
      rv.addr   = {$urandom, $urandom};
      rv.be     = 8'($urandom);
      rv.data   = {$urandom, $urandom};
      rv.user   = UW'($urandom);
      rv.lat_a  = $urandom_range(0, 3);
      rv.lat_w  = $urandom_range(0, 3);
      rv.lat_r  = $urandom_range(0, 3);
      rv.resp   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rv.rdata  = {$urandom, $urandom};
      rv.ruser  = UW'($urandom);
      rv.id_bad = $urandom_range(0, 7) == 0;
      rv.exp_rt = rv.we ? 2 + ((rv.lat_a > rv.lat_w) ? rv.lat_a : rv.lat_w) + 1 + rv.lat_r + 1
                        : 2 + rv.lat_a + 1 + rv.lat_r + 1;
      rv.exp_err  = (rv.resp != 2'b00) || (IDCHK && rv.id_bad);
      rv.exp_data = rv.we ? m_data : rv.rdata;
      rv.exp_user = rv.we ? m_user : rv.ruser;
      rv.b2b    = $urandom_range(0, 1) == 1;
      if (!rv.b2b) idle($urandom_range(1, 2));
      run_txn(rv);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
